// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Optional feature macro: DIV_ZERO_DETECT_EN (divide-by-zero short cut and flag).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DIVIDEND_W = 16;
    localparam int DIV_DIVISOR_W  = 8;

    // Counter must hold the value N itself, not just N-1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_DIVIDEND_W);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the divider; div_by_zero exists only
// when DIV_ZERO_DETECT_EN is defined.
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int N = DIV_DIVIDEND_W,
    parameter int M = DIV_DIVISOR_W
) ();

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a source holds valid and its data stable until that edge, and
    // ready may be decoded from state without depending on valid.
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic         div_by_zero;
`endif

    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef DIV_ZERO_DETECT_EN
        input  div_by_zero,
`endif
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef DIV_ZERO_DETECT_EN
        output div_by_zero,
`endif
        output in_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/seq_restoring_divider_sub_step.sv
// One restoring-division trial subtract: a - {0,b} as a ripple of full-adder
// cells with b inverted and carry-in 1; borrow is the inverted carry-out.
module div_sub_step #(
    parameter int M = 8
) (
    input  logic [M:0]   a,
    input  logic [M-1:0] b,
    output logic [M:0]   diff,
    output logic         borrow
);

    logic [M:0] b_inv;
    logic       carry;

    assign b_inv = ~{1'b0, b};

    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int i = 0; i <= M; i++) begin
            diff[i] = a[i] ^ b_inv[i] ^ carry;
            carry   = (a[i] & b_inv[i]) | (a[i] & carry) | (b_inv[i] & carry);
        end
        borrow = ~carry;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional feature macro: DIV_ZERO_DETECT_EN (divisor==0 goes straight to DONE).
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_restoring_divider_if.slave bus,
    output div_state_t           state,
    output logic [DIVISOR_W:0]   partial_rem
);

    localparam int N  = DIVIDEND_W;
    localparam int M  = DIVISOR_W;
    localparam int CW = cnt_width(N);

    logic [N-1:0]  q_reg;
    logic [M:0]    r_reg;
    logic [M-1:0]  d_reg;
    logic [CW-1:0] cnt;

    logic [M:0]    trial;
    logic [M:0]    diff;
    logic          borrow;
    logic [M:0]    r_next;
    logic [N-1:0]  q_next;

    // Bring down the next dividend bit beside the current partial remainder.
    assign trial = {r_reg[M-1:0], q_reg[N-1]};

    div_sub_step #(.M(M)) u_sub_step (
        .a      (trial),
        .b      (d_reg),
        .diff   (diff),
        .borrow (borrow)
    );

    assign r_next = borrow ? trial : diff;
    assign q_next = {q_reg[N-2:0], ~borrow};

    assign bus.in_ready = (state == IDLE);
    assign partial_rem  = r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            q_reg         <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            bus.div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_reg <= bus.dividend;
                        d_reg <= bus.divisor;
                        r_reg <= '0;
                        cnt   <= CW'(N);
`ifdef DIV_ZERO_DETECT_EN
                        if (bus.divisor == '0) begin
                            state           <= DONE;
                            bus.out_valid   <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend[M-1:0];
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.quotient  <= q_next;
                        bus.remainder <= r_next[M-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                        bus.div_by_zero <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
